// File: rtl/led_anim_engine.sv
// led_anim_engine
//   Multi-mode LED animation engine: off, chase, fill, bounce, breathe (PWM)
//   and blink. A programmable tick counter sets the animation step rate.
//
// Parameters
//   N   number of LED channels (2..32)
//   CW  step-interval counter width
//   PW  PWM resolution in bits (one PWM frame = 2^PW clk cycles)
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous active-high reset
//   enable      1 = animation advances, 0 = freeze
//   mode        0 off, 1 chase, 2 fill, 3 bounce, 4 breathe, 5 blink, 6/7 off
//   period      clk cycles per animation step (0 behaves as 1)
//   led_out     registered LED drive, bit N-1 is the leftmost LED
//   step_pulse  registered, one-cycle pulse on each animation step
module led_anim_engine #(
    parameter int N  = 8,
    parameter int CW = 16,
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic [2:0]    mode,
    input  logic [CW-1:0] period,
    output logic [N-1:0]  led_out,
    output logic          step_pulse
);

    localparam logic [2:0] MODE_OFF     = 3'd0;
    localparam logic [2:0] MODE_CHASE   = 3'd1;
    localparam logic [2:0] MODE_FILL    = 3'd2;
    localparam logic [2:0] MODE_BOUNCE  = 3'd3;
    localparam logic [2:0] MODE_BREATHE = 3'd4;
    localparam logic [2:0] MODE_BLINK   = 3'd5;

    localparam int IW  = $clog2(2 * N);
    localparam int PSW = $clog2(N);
    localparam int LW  = PW + 1;

    localparam logic [IW-1:0]  CHASE_LAST = IW'(N - 1);
    localparam logic [IW-1:0]  FILL_LAST  = IW'(2 * N - 1);
    localparam logic [PSW-1:0] POS_TOP    = PSW'(N - 1);
    localparam logic           DIR_DOWN   = 1'b0;
    localparam logic           DIR_UP     = 1'b1;

    logic [2:0]    mode_r,  mode_nx;
    logic [CW-1:0] tick_r,  tick_nx;
    logic [IW-1:0] idx_r,   idx_nx;
    logic [PSW-1:0] pos_r,  pos_nx;
    logic          dir_r,   dir_nx;
    logic [LW-1:0] lvl_r,   lvl_nx;
    logic [PW-1:0] pwm_r,   pwm_nx;
    logic          pulse_nx;
    logic [CW-1:0] term;
    logic [N-1:0]  led_nx;
    logic [LW-1:0] phase;
    logic [PW-1:0] bright;

    // Next animation state
    always_comb begin
        mode_nx  = mode_r;
        tick_nx  = tick_r;
        idx_nx   = idx_r;
        pos_nx   = pos_r;
        dir_nx   = dir_r;
        lvl_nx   = lvl_r;
        pwm_nx   = pwm_r;
        pulse_nx = 1'b0;
        term     = (period == '0) ? '0 : period - CW'(1);

        if (mode != mode_r) begin
            // Restart into the new mode, independent of enable
            mode_nx = mode;
            tick_nx = '0;
            idx_nx  = '0;
            pos_nx  = POS_TOP;
            dir_nx  = DIR_DOWN;
            lvl_nx  = '0;
            pwm_nx  = '0;
        end else if (enable) begin
            pwm_nx = pwm_r + PW'(1);
            // >= so that a shortened period wraps immediately
            if (tick_r >= term) begin
                tick_nx  = '0;
                pulse_nx = 1'b1;
                case (mode_r)
                    MODE_CHASE:   idx_nx = (idx_r >= CHASE_LAST) ? '0 : idx_r + IW'(1);
                    MODE_FILL:    idx_nx = (idx_r >= FILL_LAST) ? '0 : idx_r + IW'(1);
                    MODE_BLINK:   idx_nx = (idx_r != '0) ? '0 : IW'(1);
                    MODE_BREATHE: lvl_nx = lvl_r + LW'(1);
                    MODE_BOUNCE: begin
                        if (dir_r == DIR_DOWN) begin
                            if (pos_r == '0) begin
                                pos_nx = PSW'(1);
                                dir_nx = DIR_UP;
                            end else begin
                                pos_nx = pos_r - PSW'(1);
                            end
                        end else begin
                            if (pos_r >= POS_TOP) begin
                                pos_nx = POS_TOP - PSW'(1);
                                dir_nx = DIR_DOWN;
                            end else begin
                                pos_nx = pos_r + PSW'(1);
                            end
                        end
                    end
                    default: ;
                endcase
            end else begin
                tick_nx = tick_r + CW'(1);
            end
        end
    end

    // LED pattern derived from the next state, so led_out tracks it registered
    always_comb begin
        led_nx = '0;
        phase  = '0;
        bright = '0;
        case (mode_nx)
            MODE_CHASE: begin
                for (int unsigned i = 0; i < N; i++)
                    led_nx[i] = (idx_nx == IW'(N - 1 - i));
            end
            MODE_FILL: begin
                // Rising half sets the top s+1 bits; falling half clears from the bottom
                for (int unsigned i = 0; i < N; i++) begin
                    if (idx_nx < IW'(N))
                        led_nx[i] = ((IW'(i) + idx_nx) >= IW'(N - 1));
                    else
                        led_nx[i] = (IW'(i + N) > idx_nx);
                end
            end
            MODE_BOUNCE: begin
                for (int unsigned i = 0; i < N; i++)
                    led_nx[i] = (pos_nx == PSW'(i));
            end
            MODE_BREATHE: begin
                // Triangle brightness: upper half of the phase is mirrored via inversion
                for (int unsigned i = 0; i < N; i++) begin
                    phase     = lvl_nx + LW'(2 * i);
                    bright    = phase[PW] ? ~phase[PW-1:0] : phase[PW-1:0];
                    led_nx[i] = (pwm_nx < bright);
                end
            end
            MODE_BLINK: led_nx = (idx_nx == '0) ? '1 : '0;
            default:    led_nx = '0;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            mode_r     <= MODE_OFF;
            tick_r     <= '0;
            idx_r      <= '0;
            pos_r      <= POS_TOP;
            dir_r      <= DIR_DOWN;
            lvl_r      <= '0;
            pwm_r      <= '0;
            led_out    <= '0;
            step_pulse <= 1'b0;
        end else begin
            mode_r     <= mode_nx;
            tick_r     <= tick_nx;
            idx_r      <= idx_nx;
            pos_r      <= pos_nx;
            dir_r      <= dir_nx;
            lvl_r      <= lvl_nx;
            pwm_r      <= pwm_nx;
            led_out    <= led_nx;
            step_pulse <= pulse_nx;
        end
    end

endmodule

// File: tb/tb_led_anim_engine.sv
// tb_led_anim_engine
//   Scoreboard bench for led_anim_engine (N=8, PW=4). The stimulus process
//   drives inputs on the falling edge and pushes the reference model's
//   expected led_out/step_pulse; a monitor pops and compares after each
//   rising edge.
module tb_led_anim_engine;

    localparam int N  = 8;
    localparam int CW = 16;
    localparam int PW = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          enable = 1'b0;
    logic [2:0]    mode = 3'd0;
    logic [CW-1:0] period = 16'd1;
    logic [N-1:0]  led_out;
    logic          step_pulse;

    led_anim_engine #(.N(N), .CW(CW), .PW(PW)) dut (
        .clk        (clk),
        .rst        (rst),
        .enable     (enable),
        .mode       (mode),
        .period     (period),
        .led_out    (led_out),
        .step_pulse (step_pulse)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [N-1:0] led;
        logic         pulse;
        int           id;
    } exp_t;

    exp_t sbq[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc_id   = 0;

    // Reference model: steps since restart, ticks, PWM clocks
    int   m_mode = 0;
    int   m_tick = 0;
    int   m_k    = 0;
    int   m_c    = 0;
    logic m_pulse = 1'b0;

    function automatic logic [N-1:0] exp_pattern(input int md, input int k, input int c);
        logic [N-1:0] v;
        int s, n, t, p, lv, x, b;
        v = '0;
        case (md)
            1: v[N-1-(k % N)] = 1'b1;
            2: begin
                s = k % (2 * N);
                n = (s < N) ? s + 1 : 2 * N - 1 - s;
                for (int i = 0; i < N; i++) v[i] = (i >= N - n);
            end
            3: begin
                t = k % (2 * N - 2);
                p = (t < N) ? N - 1 - t : t - (N - 1);
                v[p] = 1'b1;
            end
            4: begin
                lv = k % (1 << (PW + 1));
                for (int i = 0; i < N; i++) begin
                    x = (lv + 2 * i) % (1 << (PW + 1));
                    b = (x < (1 << PW)) ? x : (1 << (PW + 1)) - 1 - x;
                    v[i] = (c < b);
                end
            end
            5: v = (k % 2 == 0) ? '1 : '0;
            default: v = '0;
        endcase
        return v;
    endfunction

    task automatic cycle(input logic r, input logic en, input int md, input int per);
        exp_t e;
        int   term;
        @(negedge clk);
        rst    = r;
        enable = en;
        mode   = md[2:0];
        period = per[CW-1:0];
        if (r) begin
            m_mode = 0; m_tick = 0; m_k = 0; m_c = 0; m_pulse = 1'b0;
        end else if (md != m_mode) begin
            m_mode = md; m_tick = 0; m_k = 0; m_c = 0; m_pulse = 1'b0;
        end else if (en) begin
            m_c  = (m_c + 1) % (1 << PW);
            term = (per == 0) ? 0 : per - 1;
            if (m_tick >= term) begin
                m_tick  = 0;
                m_k     = m_k + 1;
                m_pulse = 1'b1;
            end else begin
                m_tick  = m_tick + 1;
                m_pulse = 1'b0;
            end
        end else begin
            m_pulse = 1'b0;
        end
        e.led   = r ? '0 : exp_pattern(m_mode, m_k, m_c);
        e.pulse = r ? 1'b0 : m_pulse;
        e.id    = cyc_id;
        cyc_id++;
        sbq.push_back(e);
        @(posedge clk);
    endtask

    // Monitor
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (sbq.size() > 0) begin
                e = sbq.pop_front();
                n_checks++;
                if (led_out !== e.led) begin
                    n_fail++;
                    $display("FAIL led_out cyc=%0d got=%h exp=%h", e.id, led_out, e.led);
                end
                n_checks++;
                if (step_pulse !== e.pulse) begin
                    n_fail++;
                    $display("FAIL step_pulse cyc=%0d got=%b exp=%b", e.id, step_pulse, e.pulse);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int md, per;
        logic en;

        // Reset state
        #2;
        n_checks++;
        if (led_out !== '0 || step_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_state got=%h/%b exp=00/0", led_out, step_pulse);
        end
        repeat (3) cycle(1'b1, 1'b0, 0, 3);

        // Chase, period 3: 0x80, 0x40 ... back to 0x80 after 8 steps
        repeat (30) cycle(1'b0, 1'b1, 1, 3);

        // Fill, period 1: full up then drain from the bottom
        repeat (20) cycle(1'b0, 1'b1, 2, 1);

        // Bounce, period 1: 14-step cycle
        repeat (32) cycle(1'b0, 1'b1, 3, 1);

        // Breathe, period 16: covers several levels, per-clk PWM
        repeat (8 * 16 + 1) cycle(1'b0, 1'b1, 4, 16);

        // Chase to 0x20, freeze 10 clks, then switch to blink while frozen
        repeat (3) cycle(1'b0, 1'b1, 1, 1);
        repeat (10) cycle(1'b0, 1'b0, 1, 1);
        repeat (2) cycle(1'b0, 1'b0, 5, 1);

        // Blink, then asynchronous reset mid-step
        repeat (9) cycle(1'b0, 1'b1, 5, 4);
        #3;
        rst = 1'b1;
        #1;
        n_checks++;
        if (led_out !== '0 || step_pulse !== 1'b0) begin
            n_fail++;
            $display("FAIL async_rst got=%h/%b exp=00/0", led_out, step_pulse);
        end
        repeat (2) cycle(1'b1, 1'b1, 5, 4);
        repeat (4) cycle(1'b0, 1'b1, 1, 1);

        // Period 0, and period shortened mid-count
        repeat (6) cycle(1'b0, 1'b1, 3, 0);
        repeat (5) cycle(1'b0, 1'b1, 2, 9);
        repeat (5) cycle(1'b0, 1'b1, 2, 2);
        repeat (3) cycle(1'b0, 1'b1, 6, 2);
        repeat (3) cycle(1'b0, 1'b1, 7, 2);

        // Randomized stretch
        md  = 1;
        per = 2;
        for (int i = 0; i < 400; i++) begin
            en = ($urandom_range(0, 9) != 0);
            if ($urandom_range(0, 39) == 0) md = $urandom_range(0, 7);
            if ($urandom_range(0, 14) == 0) per = $urandom_range(0, 5);
            cycle(1'b0, en, md, per);
        end

        // Drain the scoreboard
        for (int i = 0; i < 10 && sbq.size() > 0; i++) @(posedge clk);
        #2;
        n_checks++;
        if (sbq.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain left=%0d exp=0", sbq.size());
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/led_anim_engine.md
LED_ANIM_ENGINE -- requirements
Module: led_anim_engine

Interface
REQ-001 Parameter N, default 8: number of LED channels, 2..32.
REQ-002 Parameter CW, default 16: step-interval counter width.
REQ-003 Parameter PW, default 4: PWM resolution in bits; one PWM frame is 2^PW clk cycles.
REQ-004 Port clk, input, 1: clock; all state changes on its rising edge.
REQ-005 Port rst, input, 1: reset, asynchronous, active-high.
REQ-006 Port enable, input, 1: 1 = animation advances; 0 = freeze.
REQ-007 Port mode, input, 3: animation select; 0 off, 1 chase, 2 fill, 3 bounce, 4 breathe, 5 blink; 6 and 7 behave as off.
REQ-008 Port period, input, CW: clk cycles per animation step; 0 is treated as 1.
REQ-009 Port led_out, output, N: registered LED drive; bit N-1 is the leftmost LED.
REQ-010 Port step_pulse, output, 1: registered; high for one cycle on each animation step.

Function
REQ-011 The tick counter shall count 0..max(period,1)-1 while enable=1; step_pulse shall be high on the cycle after the counter reaches its terminal value, and the counter shall then wrap to 0.
REQ-012 A change of period mid-count shall take effect at the next compare; a counter already >= the new terminal value shall wrap on the next enabled cycle.
REQ-013 enable=0 shall hold the tick counter, step index, PWM counter and led_out; step_pulse shall be 0.
REQ-014 Mode change: on any cycle where mode differs from registered mode_r, the block shall:
- load mode_r;
- clear the tick counter, step index and PWM counter;
- suppress step_pulse;
- drive the new mode's initial pattern on led_out at the next edge.
REQ-015 This restart shall occur regardless of enable.
REQ-016 Off: led_out = 0; steps still counted and step_pulse still generated.
REQ-017 Chase: initial pattern is one-hot bit N-1; each step shifts right by one; bit 0 wraps to bit N-1.
REQ-018 Fill: step index s runs 0..2N-1 and wraps to 0; the initial pattern is s=0.
- s<N: the top s+1 bits are set.
- s>=N: the top 2N-1-s bits are set.
REQ-019 Bounce: one-hot position p starts at N-1 and moves down to 0, then up to N-1, repeating with no dwell at the ends (period 2N-2 steps).
REQ-020 Breathe:
- Level L, PW+1 bits, increments modulo 2^(PW+1) each step.
- Channel i phase x_i = (L + 2i) mod 2^(PW+1).
- Brightness b_i = x_i if x_i < 2^PW, else 2^(PW+1)-1-x_i.
- PWM counter c, PW bits, increments every enabled clk.
- led_out[i] = (c < b_i); b_i = 0 gives always off.
REQ-021 Blink: initial pattern is all ones; each step inverts all bits.
REQ-022 Step-index arithmetic shall wrap modulo the mode's cycle length; no index shall exceed its range for any N.

Reset
REQ-023 While rst=1, the block shall force:
- led_out = 0 and step_pulse = 0;
- tick counter, step index, L and c = 0;
- mode_r = 0 and bounce direction = down.
REQ-024 On rst release, the first edge with mode != 0 shall trigger a REQ-014 restart.
REQ-025 rst asserted mid-animation shall clear all state within the same cycle, independent of clk.

Verification (N=8, PW=4)
REQ-026 Chase, period=3, enable=1, from reset:
- led_out = 0x80, then 0x40 on the next step;
- step_pulse every 3 clks;
- after 8 steps led_out = 0x80 again.
REQ-027 Fill, period=1: led_out sequence 0x80,0xC0,...,0xFF,0x7F... wrong direction is a failure; required sequence after 0xFF is 0xFE,0xFC,...,0x80,0x00, then 0x80.
REQ-028 Bounce, period=1: p sequence 7,6,...,0,1,...,7,6, i.e. led_out 0x80..0x01..0x80 with a 14-step cycle.
REQ-029 Breathe, period=16, L=5:
- channel 0 (b=5) high for exactly 5 of 16 clks per frame;
- channel 7 (x=19, b=12) high for 12 of 16 clks.
REQ-030 Chase at 0x20:
- drop enable for 10 clks: led_out holds 0x20 and no step_pulse;
- switch mode to blink while enable=0: led_out = 0xFF at the next edge.
REQ-031 Assert rst asynchronously mid-step in blink: led_out = 0 immediately; after release with mode=1, led_out = 0x80 one edge later.
